// File: rtl/capstone_pkg.sv
// Shared types and constants for the serial capture datapath.
// Frame length default, FSM states and counter sizing.
package capstone_pkg;

  localparam int CAP_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Bit counter for one serial frame; flags the final bit.
// Shared by the receive and transmit control paths.
module frame_bit_counter
  import capstone_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  assign last = (count == LAST);

endmodule

// File: rtl/result_shift_reg.sv
// Serial-in/parallel-out result capture with Valid/Ack handshake.
// Build option RX_MSB_FIRST_EN: first received bit lands in Pout MSB.
module result_shift_reg
  import capstone_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S,
  input  logic             Sin,
  input  logic             Ack,
  output logic [WIDTH-1:0] Pout,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, word;
  logic [CW-1:0]    count;
  logic             last, done, clr, en;

  frame_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (clr),
    .enable (en),
    .count  (count),
    .last   (last)
  );

`ifdef RX_MSB_FIRST_EN
  assign word = {shreg[WIDTH-2:0], Sin};
`else
  assign word = {Sin, shreg[WIDTH-1:1]};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // S wins over completion for the next state, but the word still lands.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    clr      = 1'b0;
    en       = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (S) begin
          state_nx = ST_RECV;
          clr      = 1'b1;
        end
      end
      (state == ST_RECV): begin
        en   = 1'b1;
        done = last;
        if (S) begin
          clr = 1'b1;
        end else if (last) begin
          state_nx = ST_IDLE;
          clr      = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg   <= '0;
      Pout    <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (state == ST_RECV) shreg <= word;
      if (done) begin
        Pout    <= word;
        Valid   <= 1'b1;
        Overrun <= Valid & ~Ack;
      end else if (Ack && Valid) begin
        Valid   <= 1'b0;
        Overrun <= 1'b0;
      end
    end
  end

  assign Busy = (state == ST_RECV);

  cnt_bound: assert property (
    @(posedge CLK) disable iff (!RST_N)
    count <= CW'(WIDTH - 1)
  );

endmodule

// File: tb/tb_result_shift_reg.sv
// Scoreboard bench for result_shift_reg: per-cycle expectations
// from a bit-queue reference model, popped by a separate monitor.
module tb_result_shift_reg;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         S = 1'b0;
  logic         Sin = 1'b0;
  logic         Ack = 1'b0;
  logic [W-1:0] Pout;
  logic         Valid, Busy, Overrun;

  result_shift_reg #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .S       (S),
    .Sin     (Sin),
    .Ack     (Ack),
    .Pout    (Pout),
    .Valid   (Valid),
    .Busy    (Busy),
    .Overrun (Overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] pout;
    logic         valid;
    logic         busy;
    logic         ovr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  bit           m_busy, m_valid, m_ovr;
  logic [W-1:0] m_pout;
  bit           bits[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w;
    w = '0;
    foreach (bits[i]) begin
`ifdef RX_MSB_FIRST_EN
      w[W-1-i] = bits[i];
`else
      w[i] = bits[i];
`endif
    end
    return w;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_ovr = 0;
    m_pout = '0;
    bits.delete();
  endtask

  task automatic model_step(bit s, bit sin, bit ack);
    bit done;
    done = 0;
    if (m_busy) begin
      bits.push_back(sin);
      if (bits.size() == W) done = 1;
    end
    if (done) begin
      m_pout = assemble();
      m_ovr = m_valid && !ack;
      m_valid = 1;
      m_busy = 0;
      bits.delete();
    end else if (ack && m_valid) begin
      m_valid = 0;
      m_ovr = 0;
    end
    if (s) begin
      m_busy = 1;
      bits.delete();
    end
  endtask

  task automatic push_exp();
    q.push_back({m_pout, m_valid, m_busy, m_ovr});
  endtask

  task automatic step(bit s, bit sin, bit ack);
    @(negedge CLK);
    S = s; Sin = sin; Ack = ack;
    model_step(s, sin, ack);
    push_exp();
  endtask

  task automatic send_frame(logic [W-1:0] w, bit ack_last, bit s_last);
    step(1, 0, 0);
    for (int i = 0; i < W; i++)
      step(0, w[i], (i == W-1) && ack_last);
    if (s_last) begin end
  endtask

  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_pout", 32'(Pout), 32'(e.pout));
      chk("sb_valid", 32'(Valid), 32'(e.valid));
      chk("sb_busy", 32'(Busy), 32'(e.busy));
      chk("sb_overrun", 32'(Overrun), 32'(e.ovr));
    end
  end

  initial begin
    logic [W-1:0] a4;
    model_reset();
    #3;
    chk("rst_pout", 32'(Pout), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_overrun", 32'(Overrun), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // scenario 1: A4 stream, latency S+8
    send_frame(8'hA4, 0, 0);
    @(posedge CLK); #2;
`ifdef RX_MSB_FIRST_EN
    a4 = 8'h25;
`else
    a4 = 8'hA4;
`endif
    chk("s1_pout", 32'(Pout), 32'(a4));
    chk("s1_valid", 32'(Valid), 32'h1);

    // scenario 2: ack then 6D
    step(0, 0, 1);
    send_frame(8'h6D, 0, 0);
    // scenario 3: overrun, then ack clears
    send_frame(8'hA4, 0, 0);
    send_frame(8'h6D, 0, 0);
    @(posedge CLK); #2;
    chk("s3_overrun", 32'(Overrun), 32'h1);
    step(0, 0, 1);
    // scenario 4: ack on completing edge
    send_frame(8'hA4, 0, 0);
    send_frame(8'h6D, 1, 0);
    @(posedge CLK); #2;
    chk("s4_overrun", 32'(Overrun), 32'h0);
    chk("s4_valid", 32'(Valid), 32'h1);

    // scenario 5: restart after 4 bits of FF, then 3C
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    send_frame(8'h3C, 0, 0);

    // S on the completing edge
    step(1, 0, 0);
    for (int i = 0; i < W-1; i++) step(0, 1'($urandom), 0);
    step(1, 1, 0);
    for (int i = 0; i < W; i++) step(0, 1'($urandom), 0);

    // scenario 6: async reset mid-frame
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    S = 0; Sin = 0; Ack = 0;
    #1;
    chk("ar_pout", 32'(Pout), 32'h0);
    chk("ar_valid", 32'(Valid), 32'h0);
    chk("ar_busy", 32'(Busy), 32'h0);
    chk("ar_overrun", 32'(Overrun), 32'h0);
    model_reset();
    push_exp();
    @(negedge CLK);
    RST_N = 1'b1;
    model_step(0, 0, 0);
    push_exp();
    for (int i = 0; i < 6; i++) step(0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 11) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (3) @(posedge CLK);
    #2;
    chk("sb_drain", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_shift_reg.md
Name: result_shift_reg

Overview:
Serial-in, parallel-out receiver. It is the capture end of the serial datapath, opposite the parallel-load/serial-out operand shift registers.
- Samples one result bit per CLK, LSB first, after a frame-start strobe.
- Assembles WIDTH bits, presents the word on Pout, and holds Valid until the consumer acknowledges.
- Sits at the output of the serial adder/subtractor and feeds the display/register stage.

Parameters:
WIDTH, 8, frame length in bits and width of Pout (minimum 2).

Ports:
CLK  input  1  system clock; all sampling on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
S  input  1  frame-start strobe; asserted in the same cycle as the transmitter's load strobe L.
Sin  input  1  serial data in; bit i of the frame is valid on the i-th rising edge after S.
Ack  input  1  consumer acknowledge; clears Valid.
Pout  output  WIDTH  last completed word.
Valid  output  1  Pout holds an unacknowledged word.
Busy  output  1  a frame is being received.
Overrun  output  1  sticky: a word completed while the previous one was still unacknowledged.

Behaviour:
- Reset (RST_N=0, async):
  - Pout=0, Valid=0, Busy=0, Overrun=0.
  - Shift register=0, bit count=0, state=IDLE.
  - Reset mid-frame discards the partial word; nothing is emitted after release.
- States: IDLE, RECV.
  - IDLE: on an edge with S=1, go to RECV, count=0, Busy=1. Sin is not sampled on the S edge.
  - RECV: each edge shifts Sin into the MSB of the shift register (shift right) and increments count.
  - On the WIDTH-th sample edge: Pout <= {Sin, shreg[WIDTH-1:1]}, Valid=1, Busy=0, state goes to IDLE.
- Latency: Pout and Valid update on the WIDTH-th edge after the S edge. For WIDTH=8, that is edge S+8.
- Pout changes only on frame completion. A partial frame never disturbs Pout.
- S=1 while in RECV restarts the frame: count=0, partial data discarded, Busy stays 1.
- S=1 on the completing edge: the word completes normally and the next frame starts on the same edge. Busy stays 1.
- Ack=1 with Valid=1 clears Valid and Overrun on that edge. Ack with Valid=0 has no effect.
- Completion and Ack on the same edge: Valid=1 with the new word, and Overrun is cleared (not set).
- Completion with Valid=1 and no Ack: Pout is overwritten with the new word, Valid stays 1, Overrun=1 until Ack.
- A new frame may start while Valid=1; Pout keeps the old word until the new frame completes.
- Counter width: $clog2(WIDTH+1) bits. It never exceeds WIDTH-1 in RECV and does not wrap.

Optional Feature:
Macro RX_MSB_FIRST_EN.
- Defined: the first received bit is Pout[WIDTH-1]. The shift register shifts left, inserting Sin at bit 0.
- Undefined (default): LSB first, as described above, matching the LSB-first transmitters.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package/include capstone_pkg:
  - state encoding constants ST_IDLE, ST_RECV.
  - default WIDTH constant CAP_WIDTH=8.
  - counter-width function.
- One natural sub-module: frame_bit_counter.
  - Inputs: CLK, RST_N, clear, enable.
  - Outputs: count and a last-bit flag (count==WIDTH-1).
  - Reused by the transmit-side control.
- The shift register and handshake stay in result_shift_reg.

Test Plan:
1. Reset, S=1 for one edge, then Sin=0,0,1,0,0,1,0,1 on the next 8 edges -> Pout=8'hA4 and Valid=1 exactly at edge S+8; Busy=1 for edges S..S+7.
2. Ack, then a frame of 8'h6D LSB first (1,0,1,1,0,1,1,0) -> Pout=8'h6D, Overrun=0; Pout holds 8'hA4 throughout reception if the prior Ack was withheld until completion.
3. No Ack between frames 8'hA4 and 8'h6D -> Pout=8'h6D, Valid=1, Overrun=1; Ack on the next edge -> Valid=0, Overrun=0.
4. Ack asserted on the completing edge of 8'h6D while Valid=1 from the previous frame -> Valid=1, Pout=8'h6D, Overrun=0.
5. S re-asserted after 4 bits of 8'hFF, then a full 8'h3C -> Pout=8'h3C only, completing 8 edges after the second S.
6. RST_N pulsed low after 5 bits -> all outputs 0 immediately (asynchronously); subsequent clocks without S leave Valid=0. With RX_MSB_FIRST_EN defined, the scenario-1 bit stream yields Pout=8'h25.
